// File: rtl/mem_pkg.sv
// Shared types and constants for the line-oriented backing-store controller.
package mem_pkg;

  localparam int LINE_W       = 512;  // bits per cache line
  localparam int LINE_AW      = 26;   // line-address width, {tag,index}
  localparam int HIT_LAT_DEF  = 2;    // open-row hit latency
  localparam int MISS_LAT_DEF = 12;   // row-miss latency
  localparam int CNT_W        = 8;    // latency counter width

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    GAP
  } state_t;

endpackage

// File: rtl/mem_row_buffer.sv
// Tracks the currently open row and picks the access latency for a candidate row.
module mem_row_buffer
  import mem_pkg::*;
#(
  parameter int COL_BITS = 3,
  parameter int HIT_LAT  = HIT_LAT_DEF,
  parameter int MISS_LAT = MISS_LAT_DEF,
  parameter int ROW_W    = LINE_AW - COL_BITS
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [ROW_W-1:0] look_row,
  input  logic             upd_en,
  input  logic [ROW_W-1:0] upd_row,
  output logic             hit,
  output logic [CNT_W-1:0] lat
);

  // A hit is never allowed to be slower than a miss.
  localparam int HIT_EFF = (MISS_LAT < HIT_LAT) ? MISS_LAT : HIT_LAT;

  logic [ROW_W-1:0] open_row;
  logic             open_valid;

  // Open-row register, refreshed when a transaction completes.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      open_row   <= '0;
      open_valid <= 1'b0;
    end else if (upd_en) begin
      open_row   <= upd_row;
      open_valid <= 1'b1;
    end
  end

  assign hit = open_valid && (look_row == open_row);
  assign lat = hit ? CNT_W'(HIT_EFF) : CNT_W'(MISS_LAT);

endmodule

// File: rtl/mem_controller.sv
// Backing-store controller: serves L2 refills and write-backs with row-dependent latency.
module mem_controller
  import mem_pkg::*;
#(
  parameter int TNUM_2   = 18,
  parameter int INUM_2   = 26 - TNUM_2,
  parameter int MEM_AW   = 10,
  parameter int COL_BITS = 3,
  parameter int HIT_LAT  = HIT_LAT_DEF,
  parameter int MISS_LAT = MISS_LAT_DEF
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                read_L2_MEM,
  input  logic                write_L2_MEM,
  input  logic [INUM_2-1:0]   index_L2_MEM,
  input  logic [TNUM_2-1:0]   tag_L2_MEM,
  input  logic [INUM_2-1:0]   write_index_L2_MEM,
  input  logic [TNUM_2-1:0]   write_tag_L2_MEM,
  input  logic [LINE_W-1:0]   write_data_L2_MEM,
  output logic                ready_MEM_L2,
  output logic [LINE_W-1:0]   read_data_MEM_L2
);

  localparam int ROW_W = LINE_AW - COL_BITS;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [LINE_AW-1:0] wr_line;
  logic [LINE_AW-1:0] rd_line;
  logic [LINE_W-1:0]  wr_data;
  logic               pend_rd;
  logic               acc_hit;

  logic [LINE_AW-1:0] line_rd_in;
  logic [LINE_AW-1:0] line_wr_in;
  logic [ROW_W-1:0]   acc_row;
  logic [ROW_W-1:0]   upd_row;
  logic               busy;
  logic               expire;
  logic               row_hit;
  logic [CNT_W-1:0]   row_lat;

  logic [LINE_W-1:0]  store [0:(1 << MEM_AW) - 1];

  assign line_rd_in = {tag_L2_MEM, index_L2_MEM};
  assign line_wr_in = {write_tag_L2_MEM, write_index_L2_MEM};
  assign busy       = (state == WRITE) || (state == READ);
  assign expire     = busy && (cnt <= CNT_W'(1));
  assign upd_row    = (state == WRITE) ? wr_line[LINE_AW-1:COL_BITS] : rd_line[LINE_AW-1:COL_BITS];

  // Row of the transaction about to be accepted, used for latency selection.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    acc_row = line_rd_in[LINE_AW-1:COL_BITS];
    if (state == IDLE && write_L2_MEM) acc_row = line_wr_in[LINE_AW-1:COL_BITS];
    else if (state == GAP)             acc_row = rd_line[LINE_AW-1:COL_BITS];
  end

  mem_row_buffer #(
    .COL_BITS (COL_BITS),
    .HIT_LAT  (HIT_LAT),
    .MISS_LAT (MISS_LAT),
    .ROW_W    (ROW_W)
  ) u_row_buf (
    .clk      (clk),
    .nrst     (nrst),
    .look_row (acc_row),
    // Skip the refresh when the accepted row was already the open one.
    .upd_en   (expire && !acc_hit),
    .upd_row  (upd_row),
    .hit      (row_hit),
    .lat      (row_lat)
  );

  // Transaction FSM with latency counter and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state            <= IDLE;
      cnt              <= '0;
      wr_line          <= '0;
      rd_line          <= '0;
      wr_data          <= '0;
      pend_rd          <= 1'b0;
      acc_hit          <= 1'b0;
      ready_MEM_L2     <= 1'b0;
      read_data_MEM_L2 <= '0;
    end else begin
      ready_MEM_L2 <= 1'b0;
      case (state)
        IDLE: begin
          if (write_L2_MEM) begin
            state   <= WRITE;
            wr_line <= line_wr_in;
            wr_data <= write_data_L2_MEM;
            cnt     <= row_lat;
            acc_hit <= row_hit;
            if (read_L2_MEM) begin
              rd_line <= line_rd_in;
              pend_rd <= 1'b1;
            end
          end else if (read_L2_MEM) begin
            state   <= READ;
            rd_line <= line_rd_in;
            cnt     <= row_lat;
            acc_hit <= row_hit;
          end
        end
        WRITE, READ: begin
          cnt <= (cnt == '0) ? '0 : cnt - CNT_W'(1);
          if (expire) begin
            ready_MEM_L2 <= 1'b1;
            state        <= GAP;
            if (state == READ) read_data_MEM_L2 <= store[rd_line[MEM_AW-1:0]];
          end
        end
        GAP: begin
          if (pend_rd) begin
            state   <= READ;
            pend_rd <= 1'b0;
            cnt     <= row_lat;
            acc_hit <= row_hit;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage write on write-back completion.
  // NOTE: the storage array has no reset; its contents survive nrst by design.
  always_ff @(posedge clk) begin
    if (state == WRITE && expire) store[wr_line[MEM_AW-1:0]] <= wr_data;
  end

endmodule
